clk_gate_sequencer: RTL and testbench

// - Sits downstream of the APB SoC control register block and consumes its clk_gate_o word.
// - Turns each requested per-peripheral clock-gate change into a safe sequence:
//   - disable: ask the peripheral to quiesce, wait for idle or timeout, then gate the clock;
//   - enable: ungate the clock, then hold a local reset for a fixed delay.
// - One shared FSM services one channel at a time. Outputs drive the peripheral clock gates and local resets.

---
 rtl/clk_gate_sequencer.sv | 136 +++++++++++++
 tb/tb_clk_gate_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_sequencer.sv
// Per-peripheral clock-gate sequencer.
// Turns requested clock-gate changes into safe sequences: quiesce-then-gate
// on disable, ungate-then-hold-local-reset on enable. One channel at a time,
// lowest mismatching index first.
module clk_gate_sequencer #(
    parameter int unsigned NUM_CH     = 32,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned WAKE_DELAY = 4
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [NUM_CH-1:0] clk_gate_i,
    input  logic [NUM_CH-1:0] periph_idle_i,
    input  logic              timeout_clr_i,
    output logic [NUM_CH-1:0] clk_en_o,
    output logic [NUM_CH-1:0] quiesce_req_o,
    output logic [NUM_CH-1:0] periph_rst_no,
    output logic [NUM_CH-1:0] timeout_o,
    output logic              busy_o
);

    localparam int unsigned CNT_MAX = (TIMEOUT > WAKE_DELAY) ? TIMEOUT : WAKE_DELAY;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_DELAY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_QUIESCE,
        ST_WAKE
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CH_W-1:0]   ch_q;
    logic [NUM_CH-1:0] clk_en_q;
    logic [NUM_CH-1:0] quiesce_q;
    logic [NUM_CH-1:0] rst_n_q;
    logic [NUM_CH-1:0] timeout_q;

    logic [NUM_CH-1:0] mismatch;
    logic [CH_W-1:0]   sel_ch;

    // Channels whose requested enable differs from the current gate state
    always_comb begin
        mismatch = clk_gate_i ^ clk_en_q;
    end

    // Lowest-index mismatching channel (scan from the top so the lowest wins)
    always_comb begin
        sel_ch = '0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (mismatch[i-1]) begin
                sel_ch = CH_W'(i - 1);
            end
        end
    end

    // Sequencer FSM with registered gate, quiesce, reset and timeout outputs.
    // The timeout clear is issued first so a same-cycle set on a bit overrides it.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            clk_en_q  <= '1;
            quiesce_q <= '0;
            rst_n_q   <= '1;
            timeout_q <= '0;
        end else begin
            if (timeout_clr_i) begin
                timeout_q <= '0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (|mismatch) begin
                        ch_q  <= sel_ch;
                        cnt_q <= '0;
                        if (clk_gate_i[sel_ch]) begin
                            clk_en_q[sel_ch] <= 1'b1;
                            rst_n_q[sel_ch]  <= 1'b0;
                            state_q          <= ST_WAKE;
                        end else begin
                            quiesce_q[sel_ch] <= 1'b1;
                            state_q           <= ST_QUIESCE;
                        end
                    end
                end
                ST_QUIESCE: begin
                    if (clk_gate_i[ch_q]) begin
                        // Request withdrawn: drop the quiesce, leave the clock running
                        quiesce_q[ch_q] <= 1'b0;
                        cnt_q           <= '0;
                        state_q         <= ST_IDLE;
                    end else if (periph_idle_i[ch_q] || (cnt_q == TO_LAST)) begin
                        clk_en_q[ch_q]  <= 1'b0;
                        quiesce_q[ch_q] <= 1'b0;
                        if (!periph_idle_i[ch_q]) begin
                            timeout_q[ch_q] <= 1'b1;
                        end
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAKE: begin
                    if (cnt_q == WAKE_LAST) begin
                        rst_n_q[ch_q] <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Busy whenever a channel transaction is in progress
    always_comb begin
        busy_o = (state_q != ST_IDLE);
    end

    assign clk_en_o      = clk_en_q;
    assign quiesce_req_o = quiesce_q;
    assign periph_rst_no = rst_n_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_clk_gate_sequencer.sv
// Self-checking bench for clk_gate_sequencer (NUM_CH=32, TIMEOUT=255, WAKE_DELAY=4).
// Reference model works at transaction level: each pending channel change costs a
// known number of cycles and leaves a known final gate/timeout state.
module tb_clk_gate_sequencer;

    localparam int NCH   = 32;
    localparam int TO    = 255;
    localparam int WD    = 4;
    localparam int LIMIT = 12000;

    logic            HCLK;
    logic            HRESETn;
    logic [NCH-1:0]  clk_gate_i;
    logic [NCH-1:0]  periph_idle_i;
    logic            timeout_clr_i;
    logic [NCH-1:0]  clk_en_o;
    logic [NCH-1:0]  quiesce_req_o;
    logic [NCH-1:0]  periph_rst_no;
    logic [NCH-1:0]  timeout_o;
    logic            busy_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_en;
    logic [31:0] exp_to;

    clk_gate_sequencer #(
        .NUM_CH    (NCH),
        .TIMEOUT   (TO),
        .WAKE_DELAY(WD)
    ) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .clk_gate_i   (clk_gate_i),
        .periph_idle_i(periph_idle_i),
        .timeout_clr_i(timeout_clr_i),
        .clk_en_o     (clk_en_o),
        .quiesce_req_o(quiesce_req_o),
        .periph_rst_no(periph_rst_no),
        .timeout_o    (timeout_o),
        .busy_o       (busy_o)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle invariants outside reset
    logic [31:0] prev_en;
    bit          prev_valid = 1'b0;
    always @(negedge HCLK) begin
        if (HRESETn !== 1'b1) begin
            prev_valid = 1'b0;
        end else begin
            check("quiesce_onehot0", {31'b0, $onehot0(quiesce_req_o)}, 32'd1);
            check("busy_vs_outputs", {31'b0, busy_o},
                  {31'b0, (|quiesce_req_o) || (periph_rst_no != '1)});
            check("rst_low_only_when_clocked", (~periph_rst_no) & (~clk_en_o), 32'd0);
            if (prev_valid)
                check("one_gate_change_per_cycle",
                      {31'b0, ($countones(prev_en ^ clk_en_o) <= 1)}, 32'd1);
            prev_en    = clk_en_o;
            prev_valid = 1'b1;
        end
    end

    task automatic step();
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic wait_settle(input logic [31:0] en, output int k);
        k = 0;
        while (!(busy_o === 1'b0 && clk_en_o === en) && k < LIMIT) begin
            step();
            k++;
        end
    endtask

    task automatic run_phase(input string name, input logic [31:0] gate, input logic [31:0] idle,
                             input bit clr, input logic [31:0] en, input logic [31:0] to,
                             input int cyc);
        int k;
        if (clr) begin
            timeout_clr_i = 1'b1;
            step();
            timeout_clr_i = 1'b0;
        end
        clk_gate_i    = gate;
        periph_idle_i = idle;
        wait_settle(en, k);
        check($sformatf("%s_cycles", name), k, cyc);
        check($sformatf("%s_clk_en", name), clk_en_o, en);
        check($sformatf("%s_timeout", name), timeout_o, to);
        check($sformatf("%s_quiesce", name), quiesce_req_o, 32'd0);
        check($sformatf("%s_rst_n", name), periph_rst_no, 32'hFFFF_FFFF);
    endtask

    // Transaction-cost model: predicts final state and total cycles, then runs the phase
    task automatic model_phase(input string name, input logic [31:0] gate,
                               input logic [31:0] idle, input bit clr);
        logic [31:0] new_to;
        int          cyc;
        new_to = clr ? 32'd0 : exp_to;
        cyc    = 0;
        for (int i = 0; i < NCH; i++) begin
            if (gate[i] != exp_en[i]) begin
                if (gate[i]) begin
                    cyc += 1 + WD;
                end else if (idle[i]) begin
                    cyc += 2;
                end else begin
                    cyc += 1 + TO;
                    new_to[i] = 1'b1;
                end
            end
        end
        exp_en = gate;
        exp_to = new_to;
        run_phase(name, gate, idle, clr, exp_en, exp_to, cyc);
    endtask

    typedef struct {
        logic [31:0] gate;
        logic [31:0] idle;
        bit          clr;
        logic [31:0] en;
        logic [31:0] to;
        int          cyc;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   act_cnt;
        int   lowcnt;
        int   k;

        tbl[0] = '{32'hFFFF_FFDF, 32'hFFFF_FFDF, 1'b0, 32'hFFFF_FFDF, 32'h0000_0020, 256};
        tbl[1] = '{32'hFFFF_FFDF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFDF, 32'h0000_0000, 0};
        tbl[2] = '{32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FF00, 32'h0000_0000, 14};
        tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 40};
        tbl[4] = '{32'h7FFF_FFFE, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFE, 32'h8000_0000, 258};
        tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 10};

        HCLK          = 1'b0;
        HRESETn       = 1'b0;
        clk_gate_i    = '1;
        periph_idle_i = '1;
        timeout_clr_i = 1'b0;

        repeat (3) @(negedge HCLK);
        check("rst_clk_en", clk_en_o, 32'hFFFF_FFFF);
        check("rst_quiesce", quiesce_req_o, 32'd0);
        check("rst_rst_n", periph_rst_no, 32'hFFFF_FFFF);
        check("rst_timeout", timeout_o, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        HRESETn = 1'b1;

        act_cnt = 0;
        repeat (100) begin
            step();
            if (busy_o !== 1'b0 || clk_en_o !== 32'hFFFF_FFFF || quiesce_req_o !== 32'd0)
                act_cnt++;
        end
        check("quiet_100", act_cnt, 0);
        exp_en = 32'hFFFF_FFFF;
        exp_to = 32'd0;

        // Channel 3 disable with idle already asserted: one-cycle quiesce pulse
        clk_gate_i = 32'hFFFF_FFF7;
        step();
        check("ch3_q_pulse", quiesce_req_o, 32'h0000_0008);
        check("ch3_en_still", clk_en_o, 32'hFFFF_FFFF);
        check("ch3_busy", {31'b0, busy_o}, 32'd1);
        step();
        check("ch3_q_drop", quiesce_req_o, 32'd0);
        check("ch3_gated", clk_en_o, 32'hFFFF_FFF7);
        check("ch3_idle", {31'b0, busy_o}, 32'd0);

        // Channel 3 re-enable: local reset low for exactly WAKE_DELAY cycles
        clk_gate_i = 32'hFFFF_FFFF;
        step();
        check("ch3_ungated", clk_en_o, 32'hFFFF_FFFF);
        check("ch3_rst_low", periph_rst_no, 32'hFFFF_FFF7);
        lowcnt = 1;
        while (periph_rst_no[3] === 1'b0 && lowcnt < 50) begin
            step();
            if (periph_rst_no[3] === 1'b0) lowcnt++;
        end
        check("ch3_rst_low_cycles", lowcnt, WD);
        check("ch3_rst_released", periph_rst_no, 32'hFFFF_FFFF);

        // Table-driven phases
        for (int i = 0; i < 6; i++) begin
            run_phase($sformatf("tbl%0d", i), tbl[i].gate, tbl[i].idle, tbl[i].clr,
                      tbl[i].en, tbl[i].to, tbl[i].cyc);
        end
        exp_en = 32'hFFFF_FFFF;
        exp_to = 32'h8000_0000;

        // Abort: request withdrawn during QUIESCE
        clk_gate_i    = 32'hFFFF_FFFB;
        periph_idle_i = 32'hFFFF_FFFB;
        step();
        check("abort_q_on", quiesce_req_o, 32'h0000_0004);
        repeat (10) @(posedge HCLK);
        @(negedge HCLK);
        check("abort_q_hold", quiesce_req_o, 32'h0000_0004);
        check("abort_en_hold", clk_en_o, 32'hFFFF_FFFF);
        clk_gate_i = 32'hFFFF_FFFF;
        step();
        check("abort_q_off", quiesce_req_o, 32'd0);
        check("abort_en_kept", clk_en_o, 32'hFFFF_FFFF);
        check("abort_busy", {31'b0, busy_o}, 32'd0);
        step();
        check("abort_no_retry", {31'b0, busy_o}, 32'd0);
        check("abort_timeout", timeout_o, exp_to);

        // Timeout set and clear on the same edge: set wins, other bits clear
        clk_gate_i    = ~32'h0000_1200;
        periph_idle_i = ~32'h0000_1200;
        step();
        check("sw_q_on", quiesce_req_o, 32'h0000_0200);
        repeat (254) @(posedge HCLK);
        @(negedge HCLK);
        check("sw_not_yet", clk_en_o, 32'hFFFF_FFFF);
        timeout_clr_i = 1'b1;
        step();
        timeout_clr_i = 1'b0;
        check("sw_timeout", timeout_o, 32'h0000_0200);
        check("sw_gated", clk_en_o, ~32'h0000_0200);
        wait_settle(~32'h0000_1200, k);
        check("sw_second_cycles", k, 1 + TO);
        check("sw_second_timeout", timeout_o, 32'h0000_1200);
        exp_en = ~32'h0000_1200;
        exp_to = 32'h0000_1200;
        model_phase("sw_restore", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Randomized phases against the transaction model
        for (int p = 0; p < 25; p++) begin
            logic [31:0] flip;
            logic [31:0] idle;
            bit          clr;
            flip = $urandom & $urandom & $urandom;
            idle = ~($urandom & $urandom & $urandom);
            clr  = ($urandom_range(0, 3) == 0);
            model_phase($sformatf("rnd%0d", p), exp_en ^ flip, idle, clr);
        end

        // Asynchronous reset in the middle of a WAKE sequence
        model_phase("pre_rst_all_on", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        model_phase("pre_rst_ch0_off", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
        clk_gate_i = 32'hFFFF_FFFF;
        step();
        check("wake_rst_low", periph_rst_no, 32'hFFFF_FFFE);
        @(posedge HCLK);
        #2 HRESETn = 1'b0;
        #1;
        check("arst_clk_en", clk_en_o, 32'hFFFF_FFFF);
        check("arst_quiesce", quiesce_req_o, 32'd0);
        check("arst_rst_n", periph_rst_no, 32'hFFFF_FFFF);
        check("arst_timeout", timeout_o, 32'd0);
        check("arst_busy", {31'b0, busy_o}, 32'd0);
        clk_gate_i    = 32'hFFFF_FFF0;
        periph_idle_i = 32'hFFFF_FFFF;
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        exp_en  = 32'hFFFF_FFFF;
        exp_to  = 32'd0;
        model_phase("post_rst_reseq", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
